// File: rtl/lockon_overlay_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : lockon_overlay_mixer
//  Purpose  : Frame-synchronous lock-on FSM with shot cooldown, plus a
//             two-stage pixel pipeline compositing indicator, reticle, aim
//             crosshair and bounding box over the camera stream.
//  Revision : 1.0  initial release
// ============================================================================
module lockon_overlay_mixer #(
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int COORD_W         = 10,
  parameter int LOCK_ZONE       = 30,
  parameter int LOCK_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int CH_LEN          = 22,
  parameter int AIM_LEN         = 10,
  parameter int IND_SIZE        = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               de,
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  logic [11:0]        img_bg,
  input  logic [COORD_W-1:0] aim_x,
  input  logic [COORD_W-1:0] aim_y,
  input  logic               aim_detected,
  input  logic [COORD_W-1:0] box_x_min,
  input  logic [COORD_W-1:0] box_x_max,
  input  logic [COORD_W-1:0] box_y_min,
  input  logic [COORD_W-1:0] box_y_max,
  output logic [3:0]         r_port,
  output logic [3:0]         g_port,
  output logic [3:0]         b_port,
  output logic               de_out,
  output logic               shoot,
  output logic [1:0]         lock_state,
  output logic [7:0]         shot_cnt
);

  // Signed arithmetic two bits wider than the coordinates, so differences
  // near 0 or the coordinate maximum never wrap.
  localparam int SW = COORD_W + 2;
  typedef logic signed [SW-1:0] sc_t;

  localparam sc_t CX_S   = sc_t'(H_RES / 2);
  localparam sc_t CY_S   = sc_t'(V_RES / 2);
  localparam sc_t ZONE_S = sc_t'(LOCK_ZONE);
  localparam sc_t ONE_S  = sc_t'(1);
  localparam sc_t CH_S   = sc_t'(CH_LEN);
  localparam sc_t AIM_S  = sc_t'(AIM_LEN);
  localparam sc_t IX0_S  = sc_t'(H_RES - 60);
  localparam sc_t IX1_S  = sc_t'(H_RES - 60 + IND_SIZE);
  localparam sc_t IY0_S  = sc_t'(30);
  localparam sc_t IY1_S  = sc_t'(30 + IND_SIZE);

  localparam int CNT_MAX = (LOCK_FRAMES > COOLDOWN_FRAMES) ? LOCK_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  function automatic sc_t ext(input logic [COORD_W-1:0] v);
    return sc_t'({2'b00, v});
  endfunction

  function automatic sc_t sabs(input sc_t v);
    return v[SW-1] ? -v : v;
  endfunction

  // Per-frame tracker snapshot
  logic [COORD_W-1:0] ax_q, ay_q, bx0_q, bx1_q, by0_q, by1_q;
  logic               det_q;

  // Lock-on FSM
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               shoot_q;
  logic [7:0]         shot_q;

  // Pipeline stage 1
  logic               ind_s1_q, ret_s1_q, aim_s1_q, box_s1_q, de_s1_q;
  logic [11:0]        bg_s1_q;
  state_t             st_s1_q;

  // Pipeline stage 2
  logic [11:0]        rgb_d, rgb_q;
  logic               de_out_q;

  // Zone qualification uses the live tracker inputs at the frame edge.
  logic in_zone;
  assign in_zone = aim_detected
                && (sabs(ext(aim_x) - CX_S) < ZONE_S)
                && (sabs(ext(aim_y) - CY_S) < ZONE_S);

  // Snapshot the tracker result once per frame so overlays stay stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ax_q  <= '0;
      ay_q  <= '0;
      bx0_q <= '0;
      bx1_q <= '0;
      by0_q <= '0;
      by1_q <= '0;
      det_q <= 1'b0;
    end else if (frame_start) begin
      ax_q  <= aim_x;
      ay_q  <= aim_y;
      bx0_q <= box_x_min;
      bx1_q <= box_x_max;
      by0_q <= box_y_min;
      by1_q <= box_y_max;
      det_q <= aim_detected;
    end
  end

  // Lock-on FSM: confirmation count, then periodic re-fire while held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shoot_q <= 1'b0;
      shot_q  <= 8'd0;
    end else begin
      shoot_q <= 1'b0;
      if (frame_start) begin
        if (!in_zone) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              state_q <= ST_ACQUIRE;
              cnt_q   <= CNT_ONE;
            end
            ST_ACQUIRE: begin
              if (cnt_q == LOCK_LAST) begin
                state_q <= ST_LOCKED;
                cnt_q   <= '0;
                shoot_q <= 1'b1;
                if (shot_q != 8'hFF) shot_q <= shot_q + 8'd1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            ST_LOCKED: begin
              state_q <= ST_COOLDOWN;
              cnt_q   <= CNT_ONE;
            end
            ST_COOLDOWN: begin
              if (cnt_q == COOL_LAST) begin
                state_q <= ST_LOCKED;
                cnt_q   <= '0;
                shoot_q <= 1'b1;
                if (shot_q != 8'hFF) shot_q <= shot_q + 8'd1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Overlay hit tests against the current pixel and the frame snapshot.
  sc_t  px, py, rdx, rdy, adx, ady, bx0, bx1, by0, by1;
  logic hit_ind, hit_ret, hit_aim, box_ok, on_v, on_h, hit_box;

  assign px  = ext(x_pixel);
  assign py  = ext(y_pixel);
  assign rdx = sabs(px - CX_S);
  assign rdy = sabs(py - CY_S);
  assign adx = sabs(px - ext(ax_q));
  assign ady = sabs(py - ext(ay_q));
  assign bx0 = ext(bx0_q);
  assign bx1 = ext(bx1_q);
  assign by0 = ext(by0_q);
  assign by1 = ext(by1_q);

  assign hit_ind = (px >= IX0_S) && (px < IX1_S) && (py >= IY0_S) && (py < IY1_S);
  assign hit_ret = ((rdx <= ONE_S) && (rdy <= CH_S)) || ((rdy <= ONE_S) && (rdx <= CH_S));
  assign hit_aim = det_q && (((adx <= ONE_S) && (ady <= AIM_S)) ||
                             ((ady <= ONE_S) && (adx <= AIM_S)));
  assign box_ok  = det_q && (bx0 <= bx1) && (by0 <= by1);
  assign on_v    = ((px == bx0) || (px == bx1)) && (py >= by0) && (py <= by1);
  assign on_h    = ((py == by0) || (py == by1)) && (px >= bx0) && (px <= bx1);
  assign hit_box = box_ok && (on_v || on_h);

  // Stage 1: register hit flags, background, enable and indicator state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ind_s1_q <= 1'b0;
      ret_s1_q <= 1'b0;
      aim_s1_q <= 1'b0;
      box_s1_q <= 1'b0;
      de_s1_q  <= 1'b0;
      bg_s1_q  <= 12'h000;
      st_s1_q  <= ST_IDLE;
    end else begin
      ind_s1_q <= hit_ind;
      ret_s1_q <= hit_ret;
      aim_s1_q <= hit_aim;
      box_s1_q <= hit_box;
      de_s1_q  <= de;
      bg_s1_q  <= img_bg;
      st_s1_q  <= state_q;
    end
  end

  // Priority mux: indicator > reticle > aim > box > camera; blank outside de.
  always_comb begin
    rgb_d = bg_s1_q;
    if (!de_s1_q) begin
      rgb_d = 12'h000;
    end else if (ind_s1_q) begin
      case (st_s1_q)
        ST_IDLE:     rgb_d = 12'hFFF;
        ST_ACQUIRE:  rgb_d = 12'hFF0;
        ST_LOCKED:   rgb_d = 12'hF00;
        default:     rgb_d = 12'h00F;
      endcase
    end else if (ret_s1_q) begin
      rgb_d = 12'h000;
    end else if (aim_s1_q) begin
      rgb_d = 12'hF00;
    end else if (box_s1_q) begin
      rgb_d = 12'h0F0;
    end
  end

  // Stage 2: register the composited colour and matching enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q    <= 12'h000;
      de_out_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      de_out_q <= de_s1_q;
    end
  end

  assign r_port     = rgb_q[11:8];
  assign g_port     = rgb_q[7:4];
  assign b_port     = rgb_q[3:0];
  assign de_out     = de_out_q;
  assign shoot      = shoot_q;
  assign lock_state = state_q;
  assign shot_cnt   = shot_q;

endmodule
`default_nettype wire
